// File: rtl/ssp_tx_serializer_if.sv
// SSP transmit path bundle: FIFO head/pop handshake plus serial outputs.
interface ssp_tx_serializer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  tmit;
  logic [DATA_WIDTH-1:0] txdata;
  logic                  remove;
  logic                  sspclkout;
  logic                  sspfssout;
  logic                  ssptxd;
  logic                  sspoe_b;

  // FIFO / environment side
  modport master (
    output tmit, txdata,
    input  remove, sspclkout, sspfssout, ssptxd, sspoe_b
  );

  // Serializer side
  modport slave (
    input  tmit, txdata,
    output remove, sspclkout, sspfssout, ssptxd, sspoe_b
  );
endinterface

// File: rtl/ssp_tx_serializer.sv
// SSP transmit serializer: pops the FIFO head word and shifts it out MSB-first,
// framed by a one-bit-period sync pulse, on a divided free-running serial clock.
module ssp_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 1
) (
  input logic               pclk,
  input logic               clear,
  ssp_tx_serializer_if.slave bus
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DRAIN} state_t;

  state_t                state, state_n;
  logic [CW-1:0]         div_cnt, div_n;
  logic                  sclk, sclk_n;
  logic [DATA_WIDTH-1:0] sreg, sreg_n;
  logic [BW-1:0]         bit_cnt, bit_n;
  logic                  remove_r, remove_n;
  logic                  fss_r, fss_n;
  logic                  txd_r, txd_n;
  logic                  oe_b_r, oe_b_n;
  logic                  rise;

  // Register all serializer and divider state; clear forces idle immediately.
  always_ff @(posedge pclk or posedge clear) begin
    if (clear) begin
      state    <= IDLE;
      div_cnt  <= '0;
      sclk     <= 1'b0;
      sreg     <= '0;
      bit_cnt  <= '0;
      remove_r <= 1'b0;
      fss_r    <= 1'b0;
      txd_r    <= 1'b0;
      oe_b_r   <= 1'b1;
    end else begin
      state    <= state_n;
      div_cnt  <= div_n;
      sclk     <= sclk_n;
      sreg     <= sreg_n;
      bit_cnt  <= bit_n;
      remove_r <= remove_n;
      fss_r    <= fss_n;
      txd_r    <= txd_n;
      oe_b_r   <= oe_b_n;
    end
  end

  // Divider plus next-state/output decisions, taken only on serial clock rises.
  always_comb begin
    state_n  = state;
    div_n    = div_cnt;
    sclk_n   = sclk;
    sreg_n   = sreg;
    bit_n    = bit_cnt;
    remove_n = 1'b0;
    fss_n    = fss_r;
    txd_n    = txd_r;
    oe_b_n   = oe_b_r;
    rise     = 1'b0;

    if (div_cnt == DIV_LAST) begin
      div_n  = '0;
      sclk_n = ~sclk;
      rise   = ~sclk;
    end else begin
      div_n = div_cnt + CW'(1);
    end

    if (rise) begin
      case (state)
        IDLE: begin
          if (bus.tmit) begin
            sreg_n   = bus.txdata;
            remove_n = 1'b1;
            fss_n    = 1'b1;
            oe_b_n   = 1'b0;
            txd_n    = 1'b0;
            bit_n    = '0;
            state_n  = SHIFT;
          end
        end
        SHIFT: begin
          txd_n  = sreg[DATA_WIDTH-1];
          sreg_n = sreg << 1;
          fss_n  = 1'b0;
          bit_n  = bit_cnt + BW'(1);
          // LSB goes out on this rise: the next word's sync overlaps it.
          if (bit_cnt == BIT_LAST) begin
            bit_n = '0;
            if (bus.tmit) begin
              sreg_n   = bus.txdata;
              remove_n = 1'b1;
              fss_n    = 1'b1;
            end else begin
              state_n = DRAIN;
            end
          end
        end
        DRAIN: begin
          txd_n   = 1'b0;
          oe_b_n  = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.remove    = remove_r;
  assign bus.sspclkout = sclk;
  assign bus.sspfssout = fss_r;
  assign bus.ssptxd    = txd_r;
  assign bus.sspoe_b   = oe_b_r;

endmodule

// File: tb/tb_ssp_tx_serializer.sv
// Directed bench for ssp_tx_serializer: table of frames on a CLK_DIV=1 instance,
// plus hand sequences for idle, stray tmit, mid-frame clear and CLK_DIV=3.
module tb_ssp_tx_serializer;

  logic pclk = 1'b0;
  logic clear;
  int   checks = 0;
  int   errors = 0;

  always #5 pclk = ~pclk;

  ssp_tx_serializer_if #(.DATA_WIDTH(8)) b1 ();
  ssp_tx_serializer_if #(.DATA_WIDTH(8)) b3 ();

  ssp_tx_serializer #(.DATA_WIDTH(8), .CLK_DIV(1)) dut1 (
    .pclk (pclk),
    .clear(clear),
    .bus  (b1)
  );

  ssp_tx_serializer #(.DATA_WIDTH(8), .CLK_DIV(3)) dut3 (
    .pclk (pclk),
    .clear(clear),
    .bus  (b3)
  );

  typedef struct {
    logic [7:0] word;
    logic [0:7] bits;   // expected ssptxd, first-transmitted bit at index 0
    logic       chain;  // next entry follows back-to-back
  } frame_t;

  frame_t tbl [4];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  // Advance to just after the next serial clock rise of the selected instance.
  task automatic to_rise(input int which);
    logic s0;
    logic hit;
    hit = 1'b0;
    for (int n = 0; n < 16 && !hit; n++) begin
      s0 = (which == 1) ? b1.sspclkout : b3.sspclkout;
      step();
      if (!s0 && ((which == 1) ? b1.sspclkout : b3.sspclkout)) hit = 1'b1;
    end
    chk("rise_seen", hit, 1'b1);
  endtask

  task automatic chk_idle1(input string name);
    chk({name, "_remove"}, b1.remove, 1'b0);
    chk({name, "_fss"}, b1.sspfssout, 1'b0);
    chk({name, "_txd"}, b1.ssptxd, 1'b0);
    chk({name, "_oe_b"}, b1.sspoe_b, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic       last_chain;
    logic [0:7] exp3;

    tbl[0] = '{8'hA5, 8'b10100101, 1'b0};
    tbl[1] = '{8'h3C, 8'b00111100, 1'b1};
    tbl[2] = '{8'hC3, 8'b11000011, 1'b0};
    tbl[3] = '{8'h01, 8'b00000001, 1'b0};

    clear     = 1'b1;
    b1.tmit   = 1'b0;
    b1.txdata = 8'h00;
    b3.tmit   = 1'b0;
    b3.txdata = 8'h00;

    // Reset state
    step();
    chk_idle1("rst");
    chk("rst_sclk", b1.sspclkout, 1'b0);
    chk("rst3_sclk", b3.sspclkout, 1'b0);
    chk("rst3_oe_b", b3.sspoe_b, 1'b1);
    clear = 1'b0;

    // Table-driven frames on CLK_DIV=1
    for (int k = 0; k < 4; k++) begin
      if (k == 0 || !tbl[k-1].chain) begin
        b1.txdata = tbl[k].word;
        b1.tmit   = 1'b1;
        to_rise(1);
        chk("start_remove", b1.remove, 1'b1);
        chk("start_fss", b1.sspfssout, 1'b1);
        chk("start_oe_b", b1.sspoe_b, 1'b0);
        chk("start_txd", b1.ssptxd, 1'b0);
      end
      if (tbl[k].chain) begin
        b1.txdata = tbl[k+1].word;
        b1.tmit   = 1'b1;
      end else begin
        b1.txdata = 8'hEE;
        b1.tmit   = 1'b0;
      end
      step();
      chk("remove_one_cycle", b1.remove, 1'b0);
      chk("fss_second_cycle", b1.sspfssout, 1'b1);
      for (int i = 0; i < 8; i++) begin
        to_rise(1);
        last_chain = (i == 7) && tbl[k].chain;
        chk("bit", b1.ssptxd, tbl[k].bits[i]);
        chk("bit_oe_b", b1.sspoe_b, 1'b0);
        chk("bit_remove", b1.remove, last_chain);
        chk("bit_fss", b1.sspfssout, last_chain);
      end
      if (!tbl[k].chain) begin
        to_rise(1);
        chk_idle1("drain");
      end
    end

    // FIFO empty for 20 pclk
    b1.tmit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk_idle1("empty");
    end

    // tmit high only across a non-rise edge
    to_rise(1);
    b1.tmit   = 1'b1;
    b1.txdata = 8'h5A;
    step();
    b1.tmit = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk_idle1("stray_tmit");
    end

    // Mid-frame clear after 3 bits of 0xFF
    b1.txdata = 8'hFF;
    b1.tmit   = 1'b1;
    to_rise(1);
    b1.tmit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      to_rise(1);
      chk("pre_clear_bit", b1.ssptxd, 1'b1);
    end
    #3;
    clear = 1'b1;
    #1;
    chk_idle1("async_clear");
    chk("async_clear_sclk", b1.sspclkout, 1'b0);
    step();
    step();
    chk_idle1("held_clear");
    clear = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("post_clear_sclk", b1.sspclkout, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk_idle1("post_clear");
    end

    // CLK_DIV=3, word 0x80: every period 6 pclk, sclk high for the first 3
    exp3      = 8'b10000000;
    b3.txdata = 8'h80;
    b3.tmit   = 1'b1;
    to_rise(3);
    b3.tmit = 1'b0;
    for (int b = 0; b < 9; b++) begin
      for (int c = 0; c < 6; c++) begin
        if (b != 0 || c != 0) step();
        chk("div3_sclk", b3.sspclkout, (c < 3) ? 1'b1 : 1'b0);
        chk("div3_fss", b3.sspfssout, (b == 0) ? 1'b1 : 1'b0);
        chk("div3_txd", b3.ssptxd, (b == 0) ? 1'b0 : exp3[b-1]);
        chk("div3_oe_b", b3.sspoe_b, 1'b0);
        chk("div3_remove", b3.remove, (b == 0 && c == 0) ? 1'b1 : 1'b0);
      end
    end
    step();
    chk("div3_drain_sclk", b3.sspclkout, 1'b1);
    chk("div3_drain_oe_b", b3.sspoe_b, 1'b1);
    chk("div3_drain_txd", b3.ssptxd, 1'b0);
    chk("div3_drain_remove", b3.remove, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
